// File: rtl/dmem_pkg.sv
// Shared defaults, state encoding and enable levels
// for the data-memory responder.
package dmem_pkg;

  localparam int DEF_ADDR_W = 7;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam logic ACTIVE = 1'b0;

  function automatic logic even_par(
    input logic [31:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/data_mem_responder_sat_counter.sv
// Saturating up-counter, holds at all-ones.
// Ports: clk, rst_n, i_inc (count enable), o_cnt.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: DEPTH x 32 array, comb read,
// clocked write, post-reset hardware clear, saturating
// access counters. Ports: clk, rst_n, CEN/WEN/OEN
// (active low), A, D, Q, mem_ready, rd_cnt, wr_cnt,
// drop_cnt, par_err. Optional DMEM_PARITY_EN adds a
// per-word even-parity bit and a sticky error flag.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              CEN,
  input  logic              WEN,
  input  logic              OEN,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       D,
  output logic [31:0]       Q,
  output logic              mem_ready,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic              par_err
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic [31:0]       r_mem [DEPTH];

  logic w_acc;
  logic w_ready;
  logic w_rd;
  logic w_wr;
  logic w_drop;
  logic w_q_en;

  assign w_acc   = (CEN == ACTIVE);
  assign w_ready = (r_state == READY);
  assign w_rd    = w_acc && WEN && w_ready;
  assign w_wr    = w_acc && !WEN && w_ready;
  assign w_drop  = w_acc && !w_ready;
  assign w_q_en  = w_rd && (OEN == ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      unique case (r_state)
        CLEAR: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == LAST) begin
            r_state <= READY;
          end
        end
        READY: begin
          r_state <= READY;
        end
        default: begin
          r_state <= CLEAR;
        end
      endcase
    end
  end

  // Array has no reset; the clear walk zeroes it.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_wr) begin
      r_mem[A] <= D;
    end
  end

  assign Q         = w_q_en ? r_mem[A] : '0;
  assign mem_ready = w_ready;

`ifdef DMEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_par_sticky;
  logic w_par_err;

  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_par[r_clr_ptr] <= 1'b0;
    end else if (w_wr) begin
      r_par[A] <= even_par(D);
    end
  end

  assign w_par_err = w_q_en &&
    (even_par(r_mem[A]) != r_par[A]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_sticky <= 1'b0;
    end else if (w_par_err) begin
      r_par_sticky <= 1'b1;
    end
  end

  assign par_err = w_par_err;
`else
  assign par_err = 1'b0;
`endif

  sat_counter #(.W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_rd),
    .o_cnt (rd_cnt)
  );

  sat_counter #(.W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_wr),
    .o_cnt (wr_cnt)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_drop),
    .o_cnt (drop_cnt)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder
// against an array/counter model of the memory.
module tb_data_mem_responder;

  localparam int AW   = 7;
  localparam int DEP  = 128;
  localparam int CW   = 16;
  localparam int MAXC = 65535;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CEN = 1'b1;
  logic          WEN = 1'b1;
  logic          OEN = 1'b1;
  logic [AW-1:0] A = '0;
  logic [31:0]   D = '0;
  logic [31:0]   Q;
  logic          mem_ready;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] drop_cnt;
  logic          par_err;

  data_mem_responder #(
    .ADDR_W(AW), .DEPTH(DEP), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .CEN(CEN), .WEN(WEN), .OEN(OEN),
    .A(A), .D(D), .Q(Q),
    .mem_ready(mem_ready),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .drop_cnt(drop_cnt), .par_err(par_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit run_chk = 0;

  task automatic chk(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %h expected %h",
                 nm, act, exp);
    end
  endtask

  // Model: ready once DEPTH edges have passed
  // since reset release; memory is zero then.
  logic [31:0] m_mem [DEP];
  bit          m_bad [DEP];
  int m_cyc, m_rd, m_wr, m_drop;

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  <= 0;
      m_rd   <= 0;
      m_wr   <= 0;
      m_drop <= 0;
      for (int i = 0; i < DEP; i++) begin
        m_mem[i] <= '0;
        m_bad[i] <= 1'b0;
      end
    end else begin
      if (m_cyc < DEP) m_cyc <= m_cyc + 1;
      if (!CEN) begin
        if (m_cyc >= DEP) begin
          if (WEN) begin
            m_rd <= sat(m_rd);
          end else begin
            m_wr <= sat(m_wr);
            m_mem[A] <= D;
            m_bad[A] <= 1'b0;
          end
        end else begin
          m_drop <= sat(m_drop);
        end
      end
    end
  end

  logic        e_rdy;
  logic        e_vq;
  logic [31:0] e_q;
  logic        e_pe;
  always_comb begin
    e_rdy = (m_cyc >= DEP);
    e_vq  = e_rdy && !CEN && WEN && !OEN;
    e_q   = e_vq ? m_mem[A] : 32'h0;
`ifdef DMEM_PARITY_EN
    e_pe  = e_vq && m_bad[A];
`else
    e_pe  = 1'b0;
`endif
  end

  always @(negedge clk) begin
    if (run_chk) begin
      chk("Q", Q, e_q);
      chk("mem_ready", 32'(mem_ready), 32'(e_rdy));
      chk("rd_cnt", 32'(rd_cnt), m_rd);
      chk("wr_cnt", 32'(wr_cnt), m_wr);
      chk("drop_cnt", 32'(drop_cnt), m_drop);
      chk("par_err", 32'(par_err), 32'(e_pe));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    CEN = 1'b1; WEN = 1'b1; OEN = 1'b1;
  endtask

  task automatic acc(
    input logic wen, input logic oen,
    input logic [AW-1:0] a, input logic [31:0] d
  );
    CEN = 1'b0; WEN = wen; OEN = oen;
    A = a; D = d;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!mem_ready && n < 400) begin
      step();
      n++;
    end
  endtask

  int n;

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    step();
    step();
    run_chk = 1;
    chk("rst_ready", 32'(mem_ready), 0);
    chk("rst_rd", 32'(rd_cnt), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_q", Q, 0);

    // 1: clear length with CEN idle
    rst_n = 1'b1;
    wait_ready(n);
    chk("clear_len", n, 128);
    chk("t1_wr", 32'(wr_cnt), 0);

    // 2: write then read back, OEN gating
    acc(1'b0, 1'b0, 7'd5, 32'hDEADBEEF);
    step();
    acc(1'b1, 1'b0, 7'd5, 32'h0);
    #1 chk("t2_q", Q, 32'hDEADBEEF);
    step();
    chk("t2_wr", 32'(wr_cnt), 1);
    chk("t2_rd", 32'(rd_cnt), 1);
    OEN = 1'b1;
    #1 chk("t2_oen", Q, 0);
    step();
    idle();

    // 4 + 3: mid-clear reset, write while clearing
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (60) step();
    rst_n = 1'b0;
    #1 chk("t4_rdy", 32'(mem_ready), 0);
    chk("t4_wr", 32'(wr_cnt), 0);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    acc(1'b0, 1'b0, 7'd7, 32'h12345678);
    step();
    idle();
    chk("t3_drop", 32'(drop_cnt), 1);
    wait_ready(n);
    chk("t4_len", n + 11, 128);
    acc(1'b1, 1'b0, 7'd5, 32'h0);
    #1 chk("t4_old", Q, 0);
    A = 7'd7;
    #1 chk("t3_q", Q, 0);
    step();
    idle();

    // random traffic
    for (int i = 0; i < 1000; i++) begin
      CEN = ($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1;
      WEN = 1'($urandom_range(0, 1));
      OEN = 1'($urandom_range(0, 3) == 0);
      A   = AW'($urandom_range(0, 15));
      D   = $urandom;
      step();
    end
    idle();
    step();

    // 5: rd_cnt saturation
    for (int i = 0; i < 70000; i++) begin
      acc(1'b1, 1'($urandom_range(0, 1)),
          AW'($urandom), 32'h0);
      step();
    end
    idle();
    step();
    chk("t5_sat", 32'(rd_cnt), 32'h0000FFFF);

`ifdef DMEM_PARITY_EN
    // 6: corrupt stored data bit, parity flags it
    acc(1'b0, 1'b0, 7'd3, 32'h1);
    step();
    idle();
    step();
    chk("t6_sticky0", 32'(dut.r_par_sticky), 0);
    dut.r_mem[3][0] = 1'b0;
    m_mem[3] = 32'h0;
    m_bad[3] = 1'b1;
    acc(1'b1, 1'b0, 7'd3, 32'h0);
    #1 chk("t6_q", Q, 0);
    chk("t6_perr", 32'(par_err), 1);
    step();
    idle();
    step();
    chk("t6_sticky", 32'(dut.r_par_sticky), 1);
`else
    acc(1'b1, 1'b0, 7'd5, 32'h0);
    #1 chk("t6_noperr", 32'(par_err), 0);
    step();
    idle();
    step();
`endif

    run_chk = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
